sram_bank_router: RTL and testbench

Parametrised command router between the management CPU and a bank of NUM_BANKS single-port-RW plus read-only SRAM macros. It accepts one packed command per valid/ready handshake and drives the selected bank's ports for exactly one cycle, holding every other bank idle at zero. For read commands it waits the macro read latency, then captures and returns the read data under a valid/ready response handshake.

---
 rtl/sram_bank_router_pkg.sv | 54 +++++
 rtl/sram_bank_rsp_mux.sv | 27 ++
 rtl/sram_bank_router.sv | 207 ++++++++++++++++++++
 tb/tb_sram_bank_router.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_router_pkg.sv
// Shared types and packet-layout helpers for the SRAM bank command router.
package sram_bank_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_MASK_W = DEF_DATA_W / 8;

    // Field offsets, LSB first: addr_ro, ena_ro, wdata, addr, wmask, wen, ena.
    function automatic int unsigned off_ena_ro(input int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned off_wdata(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned off_addr(input int unsigned aw, input int unsigned dw);
        return aw + 1 + dw;
    endfunction

    function automatic int unsigned off_wmask(input int unsigned aw, input int unsigned dw);
        return 2 * aw + 1 + dw;
    endfunction

    function automatic int unsigned off_wen(input int unsigned aw, input int unsigned dw);
        return 2 * aw + 1 + dw + dw / 8;
    endfunction

    function automatic int unsigned off_ena(input int unsigned aw, input int unsigned dw);
        return 2 * aw + 2 + dw + dw / 8;
    endfunction

    function automatic int unsigned pkt_width(input int unsigned aw, input int unsigned dw);
        return 2 * aw + dw + dw / 8 + 3;
    endfunction

    // Command layout at the default widths (matches the offset helpers above).
    typedef struct packed {
        logic                  ena;
        logic                  wen;
        logic [DEF_MASK_W-1:0] wmask;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic                  ena_ro;
        logic [DEF_ADDR_W-1:0] addr_ro;
    } cmd_t;

endpackage

// File: rtl/sram_bank_rsp_mux.sv
// Combinational selection of one bank's RW and RO read data by bank index.
module sram_bank_rsp_mux
    import sram_bank_router_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BANK_W    = 1
) (
    input  logic [BANK_W-1:0]           bank,
    input  logic [NUM_BANKS*DATA_W-1:0] rdata,
    input  logic [NUM_BANKS*DATA_W-1:0] rdata_ro,
    output logic [DATA_W-1:0]           rw_data_c,
    output logic [DATA_W-1:0]           ro_data_c
);

    always_comb begin
        rw_data_c = '0;
        ro_data_c = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (bank == BANK_W'(b)) begin
                rw_data_c = rdata[b*DATA_W +: DATA_W];
                ro_data_c = rdata_ro[b*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/sram_bank_router.sv
// Routes packed CPU commands to one of NUM_BANKS SRAM macros and returns read data.
// Optional statistics counters enabled by defining SRAM_BANK_ROUTER_STATS_EN.
module sram_bank_router
    import sram_bank_router_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned READ_LAT  = 1,
    localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned MASK_W   = DATA_W / 8,
    localparam int unsigned PKT_W    = pkt_width(ADDR_W, DATA_W)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        pkt_valid,
    output logic                        pkt_ready,
    input  logic [PKT_W-1:0]            pkt_data,
    input  logic [BANK_W-1:0]           pkt_bank,
    output logic [NUM_BANKS-1:0]        mem_ena,
    output logic [NUM_BANKS-1:0]        mem_wen,
    output logic [NUM_BANKS-1:0]        mem_ena_ro,
    output logic [NUM_BANKS*MASK_W-1:0] mem_wmask,
    output logic [NUM_BANKS*ADDR_W-1:0] mem_addr,
    output logic [NUM_BANKS*ADDR_W-1:0] mem_addr_ro,
    output logic [NUM_BANKS*DATA_W-1:0] mem_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata,
    input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata_ro,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_rw_vld,
    output logic                        rsp_ro_vld,
    output logic [DATA_W-1:0]           rsp_rw_data,
    output logic [DATA_W-1:0]           rsp_ro_data,
    output logic [BANK_W-1:0]           rsp_bank,
    output logic                        err_bank,
    output logic [15:0]                 wr_count,
    output logic [15:0]                 rd_count
);

    localparam int unsigned OFF_ENA_RO = off_ena_ro(ADDR_W);
    localparam int unsigned OFF_WDATA  = off_wdata(ADDR_W);
    localparam int unsigned OFF_ADDR   = off_addr(ADDR_W, DATA_W);
    localparam int unsigned OFF_WMASK  = off_wmask(ADDR_W, DATA_W);
    localparam int unsigned OFF_WEN    = off_wen(ADDR_W, DATA_W);
    localparam int unsigned OFF_ENA    = off_ena(ADDR_W, DATA_W);
    localparam int unsigned CNT_W      = $clog2(READ_LAT + 1);

    state_t              state;
    logic [CNT_W-1:0]    lat_cnt;
    logic [BANK_W-1:0]   lat_bank;
    logic                lat_rw;
    logic                lat_ro;

    logic                f_ena;
    logic                f_wen;
    logic [MASK_W-1:0]   f_wmask;
    logic [ADDR_W-1:0]   f_addr;
    logic [DATA_W-1:0]   f_wdata;
    logic                f_ena_ro;
    logic [ADDR_W-1:0]   f_addr_ro;
    logic                in_range_c;
    logic                is_read_c;
    logic [DATA_W-1:0]   sel_rw_c;
    logic [DATA_W-1:0]   sel_ro_c;

    assign f_ena     = pkt_data[OFF_ENA];
    assign f_wen     = pkt_data[OFF_WEN];
    assign f_wmask   = pkt_data[OFF_WMASK +: MASK_W];
    assign f_addr    = pkt_data[OFF_ADDR +: ADDR_W];
    assign f_wdata   = pkt_data[OFF_WDATA +: DATA_W];
    assign f_ena_ro  = pkt_data[OFF_ENA_RO];
    assign f_addr_ro = pkt_data[ADDR_W-1:0];

    assign in_range_c = (32'(pkt_bank) < NUM_BANKS);
    assign is_read_c  = (f_ena & ~f_wen) | f_ena_ro;

    // Ready is a decode of the state, forced low while reset is held.
    assign pkt_ready = (state == IDLE) && !rst_in;

    sram_bank_rsp_mux #(
        .NUM_BANKS (NUM_BANKS),
        .DATA_W    (DATA_W),
        .BANK_W    (BANK_W)
    ) u_rsp_mux (
        .bank      (lat_bank),
        .rdata     (mem_rdata),
        .rdata_ro  (mem_rdata_ro),
        .rw_data_c (sel_rw_c),
        .ro_data_c (sel_ro_c)
    );

    // Command FSM: bank strobes are one-cycle pulses, response is held until taken.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            lat_bank    <= '0;
            lat_rw      <= 1'b0;
            lat_ro      <= 1'b0;
            mem_ena     <= '0;
            mem_wen     <= '0;
            mem_ena_ro  <= '0;
            mem_wmask   <= '0;
            mem_addr    <= '0;
            mem_addr_ro <= '0;
            mem_wdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rw_vld  <= 1'b0;
            rsp_ro_vld  <= 1'b0;
            rsp_rw_data <= '0;
            rsp_ro_data <= '0;
            rsp_bank    <= '0;
            err_bank    <= 1'b0;
        end else begin
            mem_ena     <= '0;
            mem_wen     <= '0;
            mem_ena_ro  <= '0;
            mem_wmask   <= '0;
            mem_addr    <= '0;
            mem_addr_ro <= '0;
            mem_wdata   <= '0;
            err_bank    <= 1'b0;

            case (state)
                IDLE: begin
                    if (pkt_valid) begin
                        if (in_range_c) begin
                            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                                if (pkt_bank == BANK_W'(b)) begin
                                    mem_ena[b]                       <= f_ena;
                                    mem_wen[b]                       <= f_wen;
                                    mem_ena_ro[b]                    <= f_ena_ro;
                                    mem_wmask[b*MASK_W +: MASK_W]    <= f_wmask;
                                    mem_addr[b*ADDR_W +: ADDR_W]     <= f_addr;
                                    mem_addr_ro[b*ADDR_W +: ADDR_W]  <= f_addr_ro;
                                    mem_wdata[b*DATA_W +: DATA_W]    <= f_wdata;
                                end
                            end
                            if (is_read_c) begin
                                state    <= WAIT;
                                lat_cnt  <= CNT_W'(READ_LAT);
                                lat_bank <= pkt_bank;
                                lat_rw   <= f_ena & ~f_wen;
                                lat_ro   <= f_ena_ro;
                            end
                        end else begin
                            err_bank <= 1'b1;
                        end
                    end
                end

                WAIT: begin
                    if (lat_cnt == '0) begin
                        state       <= HOLD;
                        rsp_valid   <= 1'b1;
                        rsp_rw_vld  <= lat_rw;
                        rsp_ro_vld  <= lat_ro;
                        rsp_rw_data <= lat_rw ? sel_rw_c : '0;
                        rsp_ro_data <= lat_ro ? sel_ro_c : '0;
                        rsp_bank    <= lat_bank;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_BANK_ROUTER_STATS_EN
    logic wr_inc_c;
    logic rd_inc_c;

    assign wr_inc_c = (state == IDLE) && pkt_valid && in_range_c && f_ena && f_wen;
    assign rd_inc_c = (state == HOLD) && rsp_ready;

    // Saturating statistics counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_inc_c && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (rd_inc_c && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`else
    assign wr_count = '0;
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_sram_bank_router.sv
// Directed self-checking bench for sram_bank_router with three banks and READ_LAT=1.
module tb_sram_bank_router;
    import sram_bank_router_pkg::*;

    localparam int unsigned NB = 3;

`ifdef SRAM_BANK_ROUTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            pkt_valid;
    logic            pkt_ready;
    logic [54:0]     pkt_data;
    logic [1:0]      pkt_bank;
    logic [NB-1:0]   mem_ena;
    logic [NB-1:0]   mem_wen;
    logic [NB-1:0]   mem_ena_ro;
    logic [NB*4-1:0] mem_wmask;
    logic [NB*8-1:0] mem_addr;
    logic [NB*8-1:0] mem_addr_ro;
    logic [NB*32-1:0] mem_wdata;
    logic [NB*32-1:0] mem_rdata;
    logic [NB*32-1:0] mem_rdata_ro;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_rw_vld;
    logic            rsp_ro_vld;
    logic [31:0]     rsp_rw_data;
    logic [31:0]     rsp_ro_data;
    logic [1:0]      rsp_bank;
    logic            err_bank;
    logic [15:0]     wr_count;
    logic [15:0]     rd_count;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    sram_bank_router #(
        .NUM_BANKS (NB),
        .ADDR_W    (8),
        .DATA_W    (32),
        .READ_LAT  (1)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_data     (pkt_data),
        .pkt_bank     (pkt_bank),
        .mem_ena      (mem_ena),
        .mem_wen      (mem_wen),
        .mem_ena_ro   (mem_ena_ro),
        .mem_wmask    (mem_wmask),
        .mem_addr     (mem_addr),
        .mem_addr_ro  (mem_addr_ro),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rdata_ro (mem_rdata_ro),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rw_vld   (rsp_rw_vld),
        .rsp_ro_vld   (rsp_ro_vld),
        .rsp_rw_data  (rsp_rw_data),
        .rsp_ro_data  (rsp_ro_data),
        .rsp_bank     (rsp_bank),
        .err_bank     (err_bank),
        .wr_count     (wr_count),
        .rd_count     (rd_count)
    );

    // SRAM model, one-cycle latency: RW data {A, bank, 0000, addr}, RO data {B, bank, 0000, addr_ro}.
    always @(posedge clk_in) begin
        if (rst_in) begin
            mem_rdata    <= '0;
            mem_rdata_ro <= '0;
        end else begin
            for (int b = 0; b < int'(NB); b++) begin
                if (mem_ena[b] && !mem_wen[b])
                    mem_rdata[b*32 +: 32] <= {4'hA, 4'(b), 16'h0000, mem_addr[b*8 +: 8]};
                if (mem_ena_ro[b])
                    mem_rdata_ro[b*32 +: 32] <= {4'hB, 4'(b), 16'h0000, mem_addr_ro[b*8 +: 8]};
            end
        end
    end

    function automatic cmd_t mk(input logic ena, input logic wen, input logic [3:0] wmask,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                input logic ena_ro, input logic [7:0] addr_ro);
        cmd_t c;
        c.ena     = ena;
        c.wen     = wen;
        c.wmask   = wmask;
        c.addr    = addr;
        c.wdata   = wdata;
        c.ena_ro  = ena_ro;
        c.addr_ro = addr_ro;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [7:0] a;
        rst_in    = 1'b1;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        pkt_bank  = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_pkt_ready", 128'(pkt_ready), 128'(1'b0));
        chk("rst_mem_ena",   128'(mem_ena),   128'(3'b000));
        chk("rst_mem_wdata", 128'(mem_wdata), 128'(96'h0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        chk("rst_err_bank",  128'(err_bank),  128'(1'b0));
        chk("rst_wr_count",  128'(wr_count),  128'(16'd0));
        rst_in = 1'b0;
        #1;
        chk("post_rst_ready", 128'(pkt_ready), 128'(1'b1));

        // Single write to bank 1
        pkt_data  = mk(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00);
        pkt_bank  = 2'd1;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        chk("wr_ena",    128'(mem_ena),    128'(3'b010));
        chk("wr_wen",    128'(mem_wen),    128'(3'b010));
        chk("wr_ena_ro", 128'(mem_ena_ro), 128'(3'b000));
        chk("wr_wmask",  128'(mem_wmask),  128'(12'h0F0));
        chk("wr_addr",   128'(mem_addr),   128'(24'h001000));
        chk("wr_wdata",  128'(mem_wdata),  128'({32'h0, 32'hDEADBEEF, 32'h0}));
        chk("wr_ready",  128'(pkt_ready),  128'(1'b1));
        chk("wr_count1", 128'(wr_count),   128'(STATS ? 16'd1 : 16'd0));
        step();
        chk("wr_ena_clr", 128'(mem_ena),   128'(3'b000));
        chk("wr_no_rsp",  128'(rsp_valid), 128'(1'b0));

        // Read both ports of bank 0, response taken immediately
        pkt_data  = mk(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b1, 8'h20);
        pkt_bank  = 2'd0;
        pkt_valid = 1'b1;
        rsp_ready = 1'b1;
        step();
        pkt_valid = 1'b0;
        chk("rd_ena",     128'(mem_ena),     128'(3'b001));
        chk("rd_wen",     128'(mem_wen),     128'(3'b000));
        chk("rd_ena_ro",  128'(mem_ena_ro),  128'(3'b001));
        chk("rd_addr",    128'(mem_addr),    128'(24'h000010));
        chk("rd_addr_ro", 128'(mem_addr_ro), 128'(24'h000020));
        chk("rd_busy",    128'(pkt_ready),   128'(1'b0));
        step();
        chk("rd_early",   128'(rsp_valid),   128'(1'b0));
        step();
        chk("rd_valid",   128'(rsp_valid),   128'(1'b1));
        chk("rd_rw_data", 128'(rsp_rw_data), 128'(32'hA0000010));
        chk("rd_ro_data", 128'(rsp_ro_data), 128'(32'hB0000020));
        chk("rd_vlds",    128'({rsp_rw_vld, rsp_ro_vld}), 128'(2'b11));
        chk("rd_bank",    128'(rsp_bank),    128'(2'd0));
        step();
        chk("rd_done",    128'(rsp_valid),   128'(1'b0));
        chk("rd_ready",   128'(pkt_ready),   128'(1'b1));
        chk("rd_count1",  128'(rd_count),    128'(STATS ? 16'd1 : 16'd0));

        // RW-only read of bank 2 with back-pressure and a command waiting
        rsp_ready = 1'b0;
        pkt_data  = mk(1'b1, 1'b0, 4'h0, 8'h33, 32'h0, 1'b0, 8'h44);
        pkt_bank  = 2'd2;
        pkt_valid = 1'b1;
        step();
        pkt_data  = mk(1'b1, 1'b1, 4'h3, 8'h55, 32'hCAFEF00D, 1'b0, 8'h00);
        pkt_bank  = 2'd0;
        step();
        step();
        chk("bp_rw_data", 128'(rsp_rw_data), 128'(32'hA2000033));
        chk("bp_ro_data", 128'(rsp_ro_data), 128'(32'h0));
        chk("bp_vlds",    128'({rsp_rw_vld, rsp_ro_vld}), 128'(2'b10));
        chk("bp_bank",    128'(rsp_bank),    128'(2'd2));
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 128'(rsp_valid),   128'(1'b1));
            chk("bp_hold_data",  128'(rsp_rw_data), 128'(32'hA2000033));
            chk("bp_hold_ready", 128'(pkt_ready),   128'(1'b0));
            chk("bp_hold_ena",   128'(mem_ena),     128'(3'b000));
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_hs_valid",   128'(rsp_valid), 128'(1'b0));
        chk("bp_not_taken",  128'(mem_ena),   128'(3'b000));
        chk("bp_ready_back", 128'(pkt_ready), 128'(1'b1));
        step();
        pkt_valid = 1'b0;
        chk("bp_next_ena",   128'(mem_ena),   128'(3'b001));
        chk("bp_next_wen",   128'(mem_wen),   128'(3'b001));
        chk("bp_next_wmask", 128'(mem_wmask), 128'(12'h003));
        chk("bp_next_wdata", 128'(mem_wdata), 128'({64'h0, 32'hCAFEF00D}));

        // Back-to-back writes to alternating banks
        pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a         = 8'h40 + 8'(i);
            pkt_data  = mk(1'b1, 1'b1, 4'hF, a, 32'(i) + 32'h100, 1'b0, 8'h00);
            pkt_bank  = 2'(i % 2);
            step();
            chk("b2b_ena",   128'(mem_ena),   128'((i % 2 == 1) ? 3'b010 : 3'b001));
            chk("b2b_addr",  128'(mem_addr),  128'((i % 2 == 1) ? {8'h00, a, 8'h00} : {16'h0000, a}));
            chk("b2b_ready", 128'(pkt_ready), 128'(1'b1));
        end
        pkt_valid = 1'b0;
        step();
        chk("b2b_idle",   128'(mem_ena),  128'(3'b000));
        chk("b2b_wr_cnt", 128'(wr_count), 128'(STATS ? 16'd6 : 16'd0));

        // Out-of-range bank is dropped with an error pulse
        pkt_data  = mk(1'b1, 1'b0, 4'h0, 8'h12, 32'h0, 1'b1, 8'h34);
        pkt_bank  = 2'd3;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        chk("oor_err",    128'(err_bank),   128'(1'b1));
        chk("oor_ena",    128'(mem_ena),    128'(3'b000));
        chk("oor_ena_ro", 128'(mem_ena_ro), 128'(3'b000));
        chk("oor_ready",  128'(pkt_ready),  128'(1'b1));
        step();
        chk("oor_err_clr", 128'(err_bank),  128'(1'b0));
        step();
        chk("oor_no_rsp",  128'(rsp_valid), 128'(1'b0));

        // Reset during WAIT discards the read
        pkt_data  = mk(1'b1, 1'b0, 4'h0, 8'h77, 32'h0, 1'b1, 8'h88);
        pkt_bank  = 2'd1;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        chk("mid_ena", 128'(mem_ena), 128'(3'b010));
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("mid_rst_ena",   128'(mem_ena),     128'(3'b000));
        chk("mid_rst_addr",  128'(mem_addr),    128'(24'h0));
        chk("mid_rst_rsp",   128'(rsp_valid),   128'(1'b0));
        chk("mid_rst_data",  128'(rsp_rw_data), 128'(32'h0));
        chk("mid_rst_count", 128'({wr_count, rd_count}), 128'(32'h0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_rsp", 128'(rsp_valid), 128'(1'b0));
        end
        chk("mid_ready", 128'(pkt_ready), 128'(1'b1));
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        step();
        step();
        chk("re_valid",   128'(rsp_valid),   128'(1'b1));
        chk("re_rw_data", 128'(rsp_rw_data), 128'(32'hA1000077));
        chk("re_ro_data", 128'(rsp_ro_data), 128'(32'hB1000088));
        chk("re_bank",    128'(rsp_bank),    128'(2'd1));
        step();
        chk("re_done",    128'(rsp_valid),   128'(1'b0));
        chk("re_rd_cnt",  128'(rd_count),    128'(STATS ? 16'd1 : 16'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
